score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 142 ++++++++++++++
 tb/tb_score_keeper.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper
// Keeps score for a shooting game. A rising edge on start_new_game begins a
// game with SHOTS shots. Each resolved shot (a rising edge on result_valid)
// uses up one shot and, when it is a hit, raises the score, the streak and a
// short hit_flash pulse. After the last shot the game ends and the best final
// score since reset is updated.
//
// Ports:
//   clk            - clock; all state changes on its rising edge
//   rst_n          - asynchronous active-low reset
//   ena            - design enable; when low every register holds
//   result_valid   - shot resolved (may stay high for several cycles)
//   hit            - shot outcome, sampled with the result_valid rising edge
//   start_new_game - player button (level); its rising edge starts a game
//   shot_enable    - high while a game is in progress
//   shots_left     - shots remaining in the current game
//   score          - hits in the current game (saturates at 15)
//   best           - highest final score since reset
//   streak         - consecutive hits in the current game (saturates at 7)
//   game_over      - high once the last shot of a game has been resolved
//   hit_flash      - high for FLASH cycles after each scored hit
module score_keeper #(
  parameter int SHOTS = 8,
  parameter int FLASH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       result_valid,
  input  logic       hit,
  input  logic       start_new_game,
  output logic       shot_enable,
  output logic [3:0] shots_left,
  output logic [3:0] score,
  output logic [3:0] best,
  output logic [2:0] streak,
  output logic       game_over,
  output logic       hit_flash
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] shots_left_q, shots_left_d;
  logic [3:0] score_q, score_d;
  logic [3:0] best_q, best_d;
  logic [2:0] streak_q, streak_d;
  logic [3:0] flash_cnt_q, flash_cnt_d;
  logic       rv_prev_q, rv_prev_d;
  logic       start_prev_q, start_prev_d;

  logic       start_evt;
  logic       result_evt;
  logic [3:0] new_score;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shots_left_q <= 4'd0;
      score_q      <= 4'd0;
      best_q       <= 4'd0;
      streak_q     <= 3'd0;
      flash_cnt_q  <= 4'd0;
      rv_prev_q    <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shots_left_q <= shots_left_d;
      score_q      <= score_d;
      best_q       <= best_d;
      streak_q     <= streak_d;
      flash_cnt_q  <= flash_cnt_d;
      rv_prev_q    <= rv_prev_d;
      start_prev_q <= start_prev_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shots_left_d = shots_left_q;
    score_d      = score_q;
    best_d       = best_q;
    streak_d     = streak_q;
    flash_cnt_d  = flash_cnt_q;
    rv_prev_d    = rv_prev_q;
    start_prev_d = start_prev_q;
    new_score    = score_q;
    start_evt    = start_new_game & ~start_prev_q;
    result_evt   = result_valid & ~rv_prev_q;

    // The prev registers only advance while enabled, so an edge that spans
    // a disabled period is still seen on the first enabled cycle.
    if (ena) begin
      rv_prev_d    = result_valid;
      start_prev_d = start_new_game;

      if (flash_cnt_q != 4'd0) begin
        flash_cnt_d = flash_cnt_q - 4'd1;
      end

      // A start edge wins over a coincident result edge, which is dropped.
      if (start_evt) begin
        state_d      = PLAY;
        shots_left_d = 4'(SHOTS);
        score_d      = 4'd0;
        streak_d     = 3'd0;
        flash_cnt_d  = 4'd0;
      end else if (result_evt && (state_q == PLAY)) begin
        shots_left_d = shots_left_q - 4'd1;
        if (hit) begin
          new_score   = (score_q == 4'd15) ? 4'd15 : score_q + 4'd1;
          streak_d    = (streak_q == 3'd7) ? 3'd7 : streak_q + 3'd1;
          flash_cnt_d = 4'(FLASH);
        end else begin
          streak_d = 3'd0;
        end
        score_d = new_score;

        // Last shot: the final score includes this shot's outcome.
        if (shots_left_q == 4'd1) begin
          state_d = OVER;
          if (new_score > best_q) begin
            best_d = new_score;
          end
        end
      end
    end
  end

  assign shot_enable = (state_q == PLAY);
  assign game_over   = (state_q == OVER);
  assign shots_left  = shots_left_q;
  assign score       = score_q;
  assign best        = best_q;
  assign streak      = streak_q;
  assign hit_flash   = (flash_cnt_q != 4'd0);

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper
// Directed bench for score_keeper. Each step drives the inputs for one
// clock, pushes the hand-derived expected outputs onto a scoreboard queue,
// and pops/compares them one time unit after the rising edge.
module tb_score_keeper;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       result_valid;
  logic       hit;
  logic       start_new_game;
  logic       shot_enable;
  logic [3:0] shots_left;
  logic [3:0] score;
  logic [3:0] best;
  logic [2:0] streak;
  logic       game_over;
  logic       hit_flash;

  typedef struct packed {
    logic       se;
    logic       go;
    logic       hf;
    logic [3:0] sl;
    logic [3:0] sc;
    logic [3:0] bst;
    logic [2:0] sk;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks;
  int    passed;

  score_keeper #(.SHOTS(8), .FLASH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .result_valid   (result_valid),
    .hit            (hit),
    .start_new_game (start_new_game),
    .shot_enable    (shot_enable),
    .shots_left     (shots_left),
    .score          (score),
    .best           (best),
    .streak         (streak),
    .game_over      (game_over),
    .hit_flash      (hit_flash)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic se, input logic go, input logic hf,
                              input logic [3:0] sl, input logic [3:0] sc,
                              input logic [3:0] bst, input logic [2:0] sk);
    exp_t e;
    e.se  = se;
    e.go  = go;
    e.hf  = hf;
    e.sl  = sl;
    e.sc  = sc;
    e.bst = bst;
    e.sk  = sk;
    return e;
  endfunction

  // Pops the oldest expectation and compares it against the live outputs.
  task automatic checkOutput();
    exp_t  e;
    exp_t  a;
    string t;
    a.se  = shot_enable;
    a.go  = game_over;
    a.hf  = hit_flash;
    a.sl  = shots_left;
    a.sc  = score;
    a.bst = best;
    a.sk  = streak;
    checks++;
    if (exp_q.size() == 0) begin
      $error("[TB] FAIL scoreboard_empty: observed no expectation, required one");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (a === e) passed++;
      else $error("[TB] FAIL %s: observed se=%b go=%b hf=%b sl=%0d sc=%0d best=%0d sk=%0d, expected se=%b go=%b hf=%b sl=%0d sc=%0d best=%0d sk=%0d",
                  t, a.se, a.go, a.hf, a.sl, a.sc, a.bst, a.sk,
                  e.se, e.go, e.hf, e.sl, e.sc, e.bst, e.sk);
    end
  endtask

  // Drives one cycle of inputs, records what should come out, then checks.
  task automatic applyStimulus(input string tag, input logic en, input logic rv,
                               input logic h, input logic st, input exp_t e);
    ena            = en;
    result_valid   = rv;
    hit            = h;
    start_new_game = st;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    checks         = 0;
    passed         = 0;
    rst_n          = 1'b0;
    ena            = 1'b1;
    result_valid   = 1'b0;
    hit            = 1'b0;
    start_new_game = 1'b0;

    // Reset state
    #2;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    tag_q.push_back("reset");
    checkOutput();
    #10 rst_n = 1'b1;

    // Game 1: hits on shots 1,2,3,5
    applyStimulus("g1_start", 1, 0, 0, 1, mk(1, 0, 0, 8, 0, 0, 0));
    applyStimulus("g1_s1",    1, 1, 1, 0, mk(1, 0, 1, 7, 1, 0, 1));
    applyStimulus("g1_g1",    1, 0, 0, 0, mk(1, 0, 1, 7, 1, 0, 1));
    applyStimulus("g1_s2",    1, 1, 1, 0, mk(1, 0, 1, 6, 2, 0, 2));
    applyStimulus("g1_g2",    1, 0, 0, 0, mk(1, 0, 1, 6, 2, 0, 2));
    applyStimulus("g1_s3",    1, 1, 1, 0, mk(1, 0, 1, 5, 3, 0, 3));
    applyStimulus("g1_g3",    1, 0, 0, 0, mk(1, 0, 1, 5, 3, 0, 3));
    applyStimulus("g1_s4",    1, 1, 0, 0, mk(1, 0, 1, 4, 3, 0, 0));
    applyStimulus("g1_g4",    1, 0, 0, 0, mk(1, 0, 1, 4, 3, 0, 0));
    applyStimulus("g1_s5",    1, 1, 1, 0, mk(1, 0, 1, 3, 4, 0, 1));
    applyStimulus("g1_g5",    1, 0, 0, 0, mk(1, 0, 1, 3, 4, 0, 1));
    applyStimulus("g1_s6",    1, 1, 0, 0, mk(1, 0, 1, 2, 4, 0, 0));
    applyStimulus("g1_g6",    1, 0, 0, 0, mk(1, 0, 1, 2, 4, 0, 0));
    applyStimulus("g1_s7",    1, 1, 0, 0, mk(1, 0, 0, 1, 4, 0, 0));
    applyStimulus("g1_g7",    1, 0, 0, 0, mk(1, 0, 0, 1, 4, 0, 0));
    applyStimulus("g1_s8",    1, 1, 0, 0, mk(0, 1, 0, 0, 4, 4, 0));
    applyStimulus("g1_g8",    1, 0, 0, 0, mk(0, 1, 0, 0, 4, 4, 0));
    applyStimulus("over1_rv", 1, 1, 1, 0, mk(0, 1, 0, 0, 4, 4, 0));
    applyStimulus("over1_g",  1, 0, 0, 0, mk(0, 1, 0, 0, 4, 4, 0));

    // Game 2: result_valid held high for 10 cycles gives one event
    applyStimulus("g2_start", 1, 0, 0, 1, mk(1, 0, 0, 8, 0, 4, 0));
    for (int i = 1; i <= 10; i++) begin
      applyStimulus($sformatf("held_%0d", i), 1, 1, 1, 0,
                    mk(1, 0, (i <= 4), 7, 1, 4, 1));
    end
    applyStimulus("held_rel", 1, 0, 0, 0, mk(1, 0, 0, 7, 1, 4, 1));

    // Start and result edges together: start wins
    applyStimulus("coinc",    1, 1, 1, 1, mk(1, 0, 0, 8, 0, 4, 0));
    applyStimulus("coinc_g",  1, 0, 0, 0, mk(1, 0, 0, 8, 0, 4, 0));

    // Game 2 continues to a final score of 2
    applyStimulus("g2_s1",    1, 1, 1, 0, mk(1, 0, 1, 7, 1, 4, 1));
    applyStimulus("g2_g1",    1, 0, 0, 0, mk(1, 0, 1, 7, 1, 4, 1));
    applyStimulus("g2_s2",    1, 1, 1, 0, mk(1, 0, 1, 6, 2, 4, 2));
    applyStimulus("g2_g2",    1, 0, 0, 0, mk(1, 0, 1, 6, 2, 4, 2));
    applyStimulus("g2_s3",    1, 1, 0, 0, mk(1, 0, 1, 5, 2, 4, 0));
    applyStimulus("g2_g3",    1, 0, 0, 0, mk(1, 0, 1, 5, 2, 4, 0));
    for (int k = 0; k < 4; k++) begin
      applyStimulus($sformatf("g2_s%0d", k + 4), 1, 1, 0, 0, mk(1, 0, 0, 4 - k, 2, 4, 0));
      applyStimulus($sformatf("g2_g%0d", k + 4), 1, 0, 0, 0, mk(1, 0, 0, 4 - k, 2, 4, 0));
    end
    applyStimulus("g2_s8",    1, 1, 0, 0, mk(0, 1, 0, 0, 2, 4, 0));
    applyStimulus("g2_g8",    1, 0, 0, 0, mk(0, 1, 0, 0, 2, 4, 0));

    // Game 3: six hits then two misses, best rises to 6
    applyStimulus("g3_start", 1, 0, 0, 1, mk(1, 0, 0, 8, 0, 4, 0));
    for (int i = 1; i <= 6; i++) begin
      applyStimulus($sformatf("g3_s%0d", i), 1, 1, 1, 0, mk(1, 0, 1, 8 - i, i, 4, i));
      applyStimulus($sformatf("g3_g%0d", i), 1, 0, 0, 0, mk(1, 0, 1, 8 - i, i, 4, i));
    end
    applyStimulus("g3_s7",    1, 1, 0, 0, mk(1, 0, 1, 1, 6, 4, 0));
    applyStimulus("g3_g7",    1, 0, 0, 0, mk(1, 0, 1, 1, 6, 4, 0));
    applyStimulus("g3_s8",    1, 1, 0, 0, mk(0, 1, 0, 0, 6, 6, 0));
    applyStimulus("g3_g8",    1, 0, 0, 0, mk(0, 1, 0, 0, 6, 6, 0));
    applyStimulus("over3_rv", 1, 1, 1, 0, mk(0, 1, 0, 0, 6, 6, 0));
    applyStimulus("over3_g",  1, 0, 0, 0, mk(0, 1, 0, 0, 6, 6, 0));

    // Game 4: result edge arrives while disabled, seen on re-enable
    applyStimulus("g4_start", 1, 0, 0, 1, mk(1, 0, 0, 8, 0, 6, 0));
    applyStimulus("g4_idle",  1, 0, 0, 0, mk(1, 0, 0, 8, 0, 6, 0));
    applyStimulus("dis_1",    0, 1, 1, 0, mk(1, 0, 0, 8, 0, 6, 0));
    applyStimulus("dis_2",    0, 1, 1, 0, mk(1, 0, 0, 8, 0, 6, 0));
    applyStimulus("reen",     1, 1, 1, 0, mk(1, 0, 1, 7, 1, 6, 1));
    applyStimulus("reen_hold",1, 1, 1, 0, mk(1, 0, 1, 7, 1, 6, 1));
    applyStimulus("dis_flash",0, 1, 1, 0, mk(1, 0, 1, 7, 1, 6, 1));

    // Asynchronous reset mid-game, start already high at release
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    tag_q.push_back("mid_reset");
    checkOutput();
    ena            = 1'b1;
    result_valid   = 1'b0;
    hit            = 1'b0;
    start_new_game = 1'b1;
    #1 rst_n = 1'b1;
    applyStimulus("post_rst_start", 1, 0, 0, 1, mk(1, 0, 0, 8, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
